// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write port bundle for the multi-read-port register file
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int NRD  = 2,
    parameter int AW   = 5
);
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                busy;
    modport master (output rd_en, rd_addr, wr_en, wr_addr, wr_data, input rd_data, busy);
    modport slave  (input rd_en, rd_addr, wr_en, wr_addr, wr_data, output rd_data, busy);
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised NRD-read/1-write register file with clear FSM, bypass and zero register
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW:0]   NR   = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state;
    logic [AW-1:0]       clr_idx;
    logic                busy_q;
    logic [XLEN-1:0]     regs [NREGS];
    logic [NRD*XLEN-1:0] rd_q;
    logic [XLEN-1:0]     rd_nxt [NRD];
    logic                wr_ok;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NR) && !(ZERO_REG != 0 && a == '0);
    endfunction

    assign wr_ok       = bus.wr_en && addr_ok(bus.wr_addr);
    assign bus.rd_data = rd_q;
    assign bus.busy    = busy_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        assign a         = bus.rd_addr[i*AW +: AW];
        assign rd_nxt[i] = !addr_ok(a) ? '0 :
                           (BYPASS != 0 && wr_ok && bus.wr_addr == a) ? bus.wr_data : regs[a];
    end

    // clear FSM sweeps every entry after reset; writes and reads only act once READY
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy_q  <= 1'b1;
            rd_q    <= '0;
        end else if (state == CLEAR) begin
            regs[clr_idx] <= '0;
            clr_idx       <= clr_idx + 1'b1;
            rd_q          <= '0;
            if (clr_idx == LAST) begin
                state  <= READY;
                busy_q <= 1'b0;
            end
        end else begin
            if (wr_ok)
                regs[bus.wr_addr] <= bus.wr_data;
            for (int p = 0; p < NRD; p++)
                if (bus.rd_en[p])
                    rd_q[p*XLEN +: XLEN] <= rd_nxt[p];
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for two regfile_mp configurations
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NRD(2), .AW(5)) ia ();
    regfile_mp_if #(.XLEN(32), .NRD(3), .AW(5)) ib ();

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ia)
    );
    regfile_mp #(.XLEN(32), .NREGS(20), .NRD(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ib)
    );

    typedef struct {
        int          dut;
        int          port;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic want(input int dut, input int port, input logic [31:0] v, input string tag);
        exp_t e;
        e.dut  = dut;
        e.port = port;
        e.exp  = v;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, e.dut == 0 ? ia.rd_data[e.port*32 +: 32] : ib.rd_data[e.port*32 +: 32], e.exp);
        end
    endtask

    task automatic idle();
        ia.rd_en = '0;
        ia.wr_en = 1'b0;
        ib.rd_en = '0;
        ib.wr_en = 1'b0;
    endtask

    task automatic rd_a(input int p, input logic [4:0] ad);
        ia.rd_en[p]         = 1'b1;
        ia.rd_addr[p*5 +: 5] = ad;
    endtask

    task automatic rd_b(input int p, input logic [4:0] ad);
        ib.rd_en[p]         = 1'b1;
        ib.rd_addr[p*5 +: 5] = ad;
    endtask

    task automatic wr_a(input logic [4:0] ad, input logic [31:0] d);
        ia.wr_en   = 1'b1;
        ia.wr_addr = ad;
        ia.wr_data = d;
    endtask

    task automatic wr_b(input logic [4:0] ad, input logic [31:0] d);
        ib.wr_en   = 1'b1;
        ib.wr_addr = ad;
        ib.wr_data = d;
    endtask

    initial begin
        int n;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ia.rd_addr = '0;
        ia.wr_addr = '0;
        ia.wr_data = '0;
        ib.rd_addr = '0;
        ib.wr_addr = '0;
        ib.wr_data = '0;
        idle();
        repeat (3) tick();
        chk("rst_busy_a", 32'(ia.busy), 32'd1);
        chk("rst_rd_a0", ia.rd_data[31:0], 32'd0);
        chk("rst_rd_a1", ia.rd_data[63:32], 32'd0);
        chk("rst_busy_b", 32'(ib.busy), 32'd1);
        chk("rst_rd_b2", ib.rd_data[95:64], 32'd0);

        rst_a = 1'b0;
        n = 0;
        while (ia.busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("busy_cycles_a", 32'(n), 32'd32);

        for (int r = 0; r < 32; r++) begin
            rd_a(0, 5'(r));
            rd_a(1, 5'(31 - r));
            want(0, 0, 32'd0, "clr_rd_p0");
            want(0, 1, 32'd0, "clr_rd_p1");
            tick();
        end

        idle(); wr_a(5'd5, 32'hDEADBEEF); tick();
        idle(); rd_a(0, 5'd5); want(0, 0, 32'hDEADBEEF, "t2_rd_x5"); tick();

        idle(); wr_a(5'd7, 32'h1234); rd_a(0, 5'd7); rd_a(1, 5'd7);
        want(0, 0, 32'h1234, "t3_byp_p0");
        want(0, 1, 32'h1234, "t3_byp_p1");
        tick();

        idle(); wr_a(5'd0, 32'hFFFFFFFF); tick();
        idle(); rd_a(0, 5'd0); rd_a(1, 5'd0);
        want(0, 0, 32'd0, "t4_x0_p0");
        want(0, 1, 32'd0, "t4_x0_p1");
        tick();
        idle(); wr_a(5'd0, 32'hFFFFFFFF); rd_a(0, 5'd0); want(0, 0, 32'd0, "t4_x0_byp"); tick();

        idle(); wr_a(5'd31, 32'hA5A5A5A5); tick();
        idle(); rd_a(1, 5'd31); want(0, 1, 32'hA5A5A5A5, "rd_x31"); tick();

        idle(); rd_a(0, 5'd5); want(0, 0, 32'hDEADBEEF, "t5_rd"); tick();
        idle(); wr_a(5'd5, 32'hCAFEF00D);
        want(0, 0, 32'hDEADBEEF, "t5_hold1");
        want(0, 1, 32'hA5A5A5A5, "t5_hold_p1");
        tick();
        idle(); want(0, 0, 32'hDEADBEEF, "t5_hold2"); tick();
        rd_a(0, 5'd5); want(0, 0, 32'hCAFEF00D, "t5_new"); tick();

        idle();
        rst_b = 1'b0;
        repeat (10) tick();
        chk("busy_b_mid", 32'(ib.busy), 32'd1);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        n = 0;
        while (ib.busy === 1'b1 && n < 100) begin
            n++;
            if (n == 6) wr_b(5'd2, 32'h0BAD0BAD);
            else ib.wr_en = 1'b0;
            tick();
        end
        ib.wr_en = 1'b0;
        chk("busy_cycles_b", 32'(n), 32'd20);

        idle(); rd_b(0, 5'd2); rd_b(1, 5'd10); rd_b(2, 5'd19);
        want(1, 0, 32'd0, "b_busy_wr_x2");
        want(1, 1, 32'd0, "b_clr_x10");
        want(1, 2, 32'd0, "b_clr_x19");
        tick();

        idle(); wr_b(5'd7, 32'h1234); rd_b(1, 5'd7); want(1, 1, 32'd0, "t3_nobyp"); tick();
        idle(); rd_b(1, 5'd7); want(1, 1, 32'h1234, "t3_after"); tick();

        idle(); wr_b(5'd0, 32'hFFFFFFFF); tick();
        idle(); rd_b(0, 5'd0); rd_b(1, 5'd0); rd_b(2, 5'd0);
        want(1, 0, 32'hFFFFFFFF, "t4_nz_p0");
        want(1, 1, 32'hFFFFFFFF, "t4_nz_p1");
        want(1, 2, 32'hFFFFFFFF, "t4_nz_p2");
        tick();

        idle(); wr_b(5'd19, 32'h99); tick();
        idle(); wr_b(5'd25, 32'h55); tick();
        idle(); rd_b(0, 5'd19); rd_b(1, 5'd5); rd_b(2, 5'd25);
        want(1, 0, 32'h99, "t6_x19");
        want(1, 1, 32'd0, "t6_no_alias");
        want(1, 2, 32'd0, "t6_x25");
        tick();

        idle();
        rst_a = 1'b1;
        tick();
        chk("rerst_busy_a", 32'(ia.busy), 32'd1);
        chk("rerst_rd_a0", ia.rd_data[31:0], 32'd0);
        rst_a = 1'b0;
        n = 0;
        while (ia.busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("rerst_cycles_a", 32'(n), 32'd32);
        rd_a(0, 5'd5); want(0, 0, 32'd0, "rerst_x5"); tick();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end
endmodule
